// File: rtl/onehot_strobe_gen_if.sv
// Handshake and strobe bus of the one-hot strobe sequencer.
// The master drives indices in; the slave (the sequencer) drives the strobe bus out.
interface onehot_strobe_gen_if #(
  parameter int DEPTH = 4
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    in_addr;
  logic [15:0]   onehot;
  logic          strobe_active;
  logic [3:0]    strobe_addr;
  logic [LW-1:0] fifo_level;
  logic          busy;

  modport master (
    output flush, in_valid, in_addr,
    input  in_ready, onehot, strobe_active, strobe_addr, fifo_level, busy
  );

  modport slave (
    input  flush, in_valid, in_addr,
    output in_ready, onehot, strobe_active, strobe_addr, fifo_level, busy
  );
endinterface

// File: rtl/onehot_strobe_gen.sv
// Queues 4-bit indices and replays each one as a timed 16-bit one-hot strobe,
// with an optional all-zero gap between consecutive strobes.
module onehot_strobe_gen #(
  parameter int DEPTH     = 4,
  parameter int PULSE_LEN = 1,
  parameter int GAP_LEN   = 0
) (
  input logic              clk,
  input logic              rst_n,
  onehot_strobe_gen_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [3:0] PULSE_CNT = 4'(PULSE_LEN - 1);
  localparam logic [3:0] GAP_CNT   = 4'((GAP_LEN > 0) ? GAP_LEN - 1 : 0);

  // The cycle counter is 4 bits wide, which bounds both lengths.
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("onehot_strobe_gen: DEPTH must be a power of two >= 2");
  end
  if (PULSE_LEN < 1 || PULSE_LEN > 15) begin : g_bad_pulse
    $error("onehot_strobe_gen: PULSE_LEN must be in 1..15");
  end
  if (GAP_LEN < 0 || GAP_LEN > 15) begin : g_bad_gap
    $error("onehot_strobe_gen: GAP_LEN must be in 0..15");
  end

  typedef enum logic [1:0] {
    IDLE,
    ASSERT,
    GAP
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [15:0]   onehot_q, onehot_d;
  logic [3:0]    addr_q, addr_d;

  logic [3:0]    mem_q [DEPTH];
  logic [AW-1:0] rdPtr_q, wrPtr_q;
  logic [LW-1:0] count_q;

  logic          full, empty, push, pop, takeNext, strobeActive;
  logic [3:0]    head;

  assign full  = (count_q == LW'(DEPTH));
  assign empty = (count_q == '0);
  assign head  = mem_q[rdPtr_q];

  // A flush cycle drops the offered index even though in_ready is high.
  assign bus.in_ready = !full && rst_n;
  assign push         = bus.in_valid && bus.in_ready && !bus.flush;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wrPtr_q] <= bus.in_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || bus.flush) begin
      rdPtr_q <= '0;
      wrPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        wrPtr_q <= wrPtr_q + 1'b1;
      end
      if (pop) begin
        rdPtr_q <= rdPtr_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    onehot_d = onehot_q;
    addr_d   = addr_q;
    pop      = 1'b0;
    takeNext = 1'b0;

    case (state_q)
      IDLE: takeNext = 1'b1;
      ASSERT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else if (GAP_LEN > 0) begin
          onehot_d = '0;
          addr_d   = '0;
          cnt_d    = GAP_CNT;
          state_d  = GAP;
        end else begin
          takeNext = 1'b1;
        end
      end
      GAP: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          takeNext = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Ending a strobe or gap and launching the next one share a cycle,
    // which is what makes zero-gap strobes run back to back.
    if (takeNext) begin
      if (!empty) begin
        pop      = 1'b1;
        onehot_d = 16'd1 << head;
        addr_d   = head;
        cnt_d    = PULSE_CNT;
        state_d  = ASSERT;
      end else begin
        onehot_d = '0;
        addr_d   = '0;
        cnt_d    = '0;
        state_d  = IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || bus.flush) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      onehot_q <= '0;
      addr_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      onehot_q <= onehot_d;
      addr_q   <= addr_d;
    end
  end

  assign strobeActive      = |onehot_q;
  assign bus.onehot        = onehot_q;
  assign bus.strobe_active = strobeActive;
  assign bus.strobe_addr   = addr_q;
  assign bus.fifo_level    = count_q;
  assign bus.busy          = strobeActive || !empty || (state_q == GAP);
endmodule

// File: tb/tb_onehot_strobe_gen.sv
// Drives two sequencer configurations with directed and random traffic and compares
// every cycle against a schedule computed from strobe start/end times.
module tb_onehot_strobe_gen;
  localparam int DEPTH = 4;
  localparam int P0 = 1, G0 = 0;
  localparam int P1 = 4, G1 = 2;

  typedef struct {
    int addr;
    int pushT;
    int st;
    int pe;
    int ge;
    int dut;
  } ent_t;

  logic clk = 1'b0;
  logic rstN;
  always #5 clk = ~clk;

  onehot_strobe_gen_if #(.DEPTH(DEPTH)) ifA ();
  onehot_strobe_gen_if #(.DEPTH(DEPTH)) ifB ();

  onehot_strobe_gen #(.DEPTH(DEPTH), .PULSE_LEN(P0), .GAP_LEN(G0)) dutA (
    .clk(clk), .rst_n(rstN), .bus(ifA)
  );
  onehot_strobe_gen #(.DEPTH(DEPTH), .PULSE_LEN(P1), .GAP_LEN(G1)) dutB (
    .clk(clk), .rst_n(rstN), .bus(ifB)
  );

  ent_t ents[$];
  int   nextAvail[2];
  bit   acc[2];
  bit   vld[2];
  int   adr[2];
  bit   fl;
  int   cyc;
  int   checks;
  int   errors;

  function automatic int pLen(int d);
    return (d == 0) ? P0 : P1;
  endfunction

  function automatic int gLen(int d);
    return (d == 0) ? G0 : G1;
  endfunction

  function automatic int level(int d, int t);
    int n = 0;
    foreach (ents[i])
      if (ents[i].dut == d && ents[i].pushT <= t && ents[i].st > t) n++;
    return n;
  endfunction

  // Each accepted index starts one edge after its push, or as soon as the
  // previous strobe plus its gap is over, whichever is later.
  function automatic bit modelEdge(int d, int e, bit v, int a, bit f, bit r);
    ent_t tmp;
    int   st;
    if (!r || f) begin
      for (int i = ents.size() - 1; i >= 0; i--) begin
        if (ents[i].dut == d) begin
          if (ents[i].st >= e) ents.delete(i);
          else begin
            tmp = ents[i];
            if (tmp.pe > e) tmp.pe = e;
            if (tmp.ge > e) tmp.ge = e;
            ents[i] = tmp;
          end
        end
      end
      nextAvail[d] = 0;
      return 1'b0;
    end
    if (v && level(d, e - 1) < DEPTH) begin
      st = (e + 1 > nextAvail[d]) ? e + 1 : nextAvail[d];
      tmp = '{addr: a, pushT: e, st: st, pe: st + pLen(d), ge: st + pLen(d) + gLen(d), dut: d};
      ents.push_back(tmp);
      nextAvail[d] = st + pLen(d) + gLen(d);
      return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic int priEnc(logic [15:0] v);
    for (int i = 0; i < 16; i++) if (v[i]) return i;
    return 0;
  endfunction

  task automatic chk(string tag, int d, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s dut%0d cyc %0d observed %0h expected %0h", tag, d, cyc, obs, exp);
    end
  endtask

  task automatic checkOutput();
    logic [15:0] oh, expOh;
    logic [3:0]  sa;
    logic        act, bsy, rdy;
    logic [2:0]  lv;
    int          expAddr, expLvl;
    bit          inGap, expAct;
    for (int d = 0; d < 2; d++) begin
      if (d == 0) begin
        oh = ifA.onehot; sa = ifA.strobe_addr; act = ifA.strobe_active;
        bsy = ifA.busy; rdy = ifA.in_ready; lv = ifA.fifo_level;
      end else begin
        oh = ifB.onehot; sa = ifB.strobe_addr; act = ifB.strobe_active;
        bsy = ifB.busy; rdy = ifB.in_ready; lv = ifB.fifo_level;
      end
      expOh = '0; expAddr = 0; expAct = 1'b0; inGap = 1'b0;
      expLvl = level(d, cyc);
      foreach (ents[i]) begin
        if (ents[i].dut == d) begin
          if (ents[i].st <= cyc && cyc < ents[i].pe) begin
            expAct = 1'b1;
            expAddr = ents[i].addr;
            expOh = 16'd1 << expAddr;
          end
          if (ents[i].pe <= cyc && cyc < ents[i].ge) inGap = 1'b1;
        end
      end
      chk("onehot", d, 32'(oh), 32'(expOh));
      chk("strobe_addr", d, 32'(sa), 32'(expAddr));
      chk("strobe_active", d, 32'(act), 32'(expAct));
      chk("fifo_level", d, 32'(lv), 32'(expLvl));
      chk("busy", d, 32'(bsy), 32'(expAct || expLvl > 0 || inGap));
      chk("in_ready", d, 32'(rdy), 32'(rstN && expLvl < DEPTH));
      chk("popcount_le1", d, 32'($countones(oh) <= 1), 32'd1);
      if (expAct) chk("encoder_roundtrip", d, 32'(priEnc(oh)), 32'(expAddr));
    end
  endtask

  task automatic stepCycle();
    ifA.in_valid = vld[0]; ifA.in_addr = 4'(adr[0]); ifA.flush = fl;
    ifB.in_valid = vld[1]; ifB.in_addr = 4'(adr[1]); ifB.flush = fl;
    for (int d = 0; d < 2; d++) acc[d] = modelEdge(d, cyc + 1, vld[d], adr[d], fl, rstN);
    for (int i = ents.size() - 1; i >= 0; i--) if (ents[i].ge < cyc) ents.delete(i);
    @(posedge clk);
    cyc++;
    @(negedge clk);
    checkOutput();
  endtask

  task automatic applyStimulus(bit v, int a, bit f, bit r, int n);
    for (int k = 0; k < n; k++) begin
      vld[0] = v; vld[1] = v; adr[0] = a; adr[1] = a; fl = f; rstN = r;
      stepCycle();
    end
  endtask

  // Holds in_valid on each DUT until it has accepted every index first..last.
  task automatic pushSeq(int first, int last, int budget);
    int nxt[2];
    int n = 0;
    nxt[0] = first; nxt[1] = first;
    fl = 1'b0; rstN = 1'b1;
    while ((nxt[0] <= last || nxt[1] <= last) && n < budget) begin
      for (int d = 0; d < 2; d++) begin
        vld[d] = (nxt[d] <= last);
        adr[d] = nxt[d] & 15;
      end
      stepCycle();
      for (int d = 0; d < 2; d++) if (acc[d]) nxt[d]++;
      n++;
    end
    chk("push_budget", 0, 32'(nxt[0] > last && nxt[1] > last), 32'd1);
  endtask

  initial begin
    checks = 0; errors = 0; cyc = 0;
    nextAvail[0] = 0; nextAvail[1] = 0;
    vld[0] = 0; vld[1] = 0; adr[0] = 0; adr[1] = 0; fl = 0; rstN = 1'b0;
    ifA.in_valid = 0; ifA.in_addr = 0; ifA.flush = 0;
    ifB.in_valid = 0; ifB.in_addr = 0; ifB.flush = 0;

    applyStimulus(0, 0, 0, 0, 3);
    applyStimulus(0, 0, 0, 1, 2);

    applyStimulus(1, 5, 0, 1, 1);
    applyStimulus(0, 0, 0, 1, 10);

    applyStimulus(1, 0, 0, 1, 1);
    applyStimulus(1, 15, 0, 1, 1);
    applyStimulus(0, 0, 0, 1, 16);

    applyStimulus(1, 3, 0, 1, 1);
    applyStimulus(1, 4, 0, 1, 1);
    applyStimulus(0, 0, 0, 1, 16);

    pushSeq(1, 6, 80);
    applyStimulus(0, 0, 0, 1, 40);

    applyStimulus(1, 7, 0, 1, 1);
    applyStimulus(1, 8, 0, 1, 1);
    applyStimulus(1, 9, 0, 1, 1);
    applyStimulus(1, 10, 1, 1, 1);
    applyStimulus(0, 0, 0, 1, 12);

    applyStimulus(1, 2, 0, 1, 1);
    applyStimulus(1, 3, 0, 1, 1);
    applyStimulus(1, 4, 0, 1, 1);
    applyStimulus(1, 11, 0, 0, 2);
    applyStimulus(0, 0, 0, 1, 12);

    pushSeq(0, 15, 200);
    applyStimulus(0, 0, 0, 1, 120);

    for (int k = 0; k < 300; k++)
      applyStimulus($urandom_range(0, 2) != 0, $urandom_range(0, 15),
                    $urandom_range(0, 59) == 0, $urandom_range(0, 99) != 0, 1);
    for (int k = 0; k < 300; k++)
      applyStimulus($urandom_range(0, 7) == 0, $urandom_range(0, 15),
                    $urandom_range(0, 79) == 0, 1'b1, 1);
    applyStimulus(0, 0, 0, 1, 60);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/onehot_strobe_gen.md
# onehot_strobe_gen

Sequencer that turns queued 4-bit addresses back into timed 16-bit one-hot strobes. It is the inverse of the priority encoder that compresses 16 request lines into a 4-bit index. Upstream logic (interrupt acknowledge, peripheral select, debug probes) pushes an index through a valid/ready handshake. The block buffers indices in a small FIFO and drives exactly one select line per entry, for a programmable width, with an optional idle gap between strobes.

## Interface
- DEPTH, 4: FIFO entries; power of two, ≥2.
- PULSE_LEN, 1: cycles each strobe is held; legal 1..15.
- GAP_LEN, 0: all-zero cycles inserted after each strobe; legal 0..15.

- clk  input  1  sole clock; all logic on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- flush  input  1  synchronous clear of FIFO and sequencer.
- in_valid  input  1  upstream offers in_addr.
- in_ready  output  1  block accepts; = !full && rst_n.
- in_addr  input  4  index to strobe (0..15).
- onehot  output  16  registered strobe bus; bit in_addr set while active, else 0.
- strobe_active  output  1  high exactly when onehot != 0.
- strobe_addr  output  4  encoded index of current strobe; 0 when inactive.
- fifo_level  output  $clog2(DEPTH)+1  entries queued, excluding the strobe in flight.
- busy  output  1  strobe_active | (fifo_level != 0) | (state == GAP).

## Operation
- Transfer: in_valid && in_ready at a rising edge writes in_addr to the FIFO tail. in_ready depends only on full, so there is no write-through-when-full.
- FIFO: circular buffer with wrapping rd/wr pointers and a count. A push and a pop in the same cycle leave the count unchanged.
- FSM states: IDLE, ASSERT, GAP.
  - IDLE: if the FIFO is non-empty, pop the head. Load onehot = 1<<head and strobe_addr = head. Load cnt = PULSE_LEN-1 and go to ASSERT. Otherwise stay.
  - ASSERT: if cnt != 0, decrement. If cnt == 0 and GAP_LEN > 0, clear onehot, load cnt = GAP_LEN-1 and go to GAP. If cnt == 0 and GAP_LEN == 0, act as IDLE in the same cycle: pop the next entry directly (back-to-back strobes with no zero cycle), or clear onehot and go to IDLE if the FIFO is empty.
  - GAP: onehot = 0. When cnt == 0, apply the IDLE decision in the same cycle (pop and go to ASSERT, or go to IDLE). Otherwise decrement.
- Output rule: onehot never has more than one bit set. Every accepted index produces exactly one strobe, in FIFO order.
- flush: takes priority over push and pop in its cycle. After the edge the FIFO is empty, the state is IDLE, and onehot = 0. An in_valid coincident with flush is dropped, even though in_ready is high.
- Counter width is 4 bits; PULSE_LEN/GAP_LEN outside 1..15 / 0..15 are illegal (elaboration check).

## Timing
- Reset (rst_n low at an edge): onehot = 0, strobe_active = 0, strobe_addr = 0, fifo_level = 0, state = IDLE, pointers = 0, busy = 0.
- While rst_n is low, in_ready = 0 and no writes are accepted. After reset releases, in_ready = 1.
- Latency: a transfer at edge k puts onehot[in_addr] high from edge k+1 (FSM idle, FIFO empty). There is no combinational bypass from in_addr to onehot.
- The strobe is high for exactly PULSE_LEN cycles, followed by exactly GAP_LEN zero cycles before the next strobe if one is queued.
- Sustained throughput is one index per PULSE_LEN+GAP_LEN cycles.
- Reset or flush mid-pulse truncates the strobe at that edge; no partial strobe resumes.

## Test plan
- Single: PULSE=1, GAP=0. Push addr 5 at edge k → onehot = 0x0020 for cycle k+1 only, strobe_addr = 5, then 0x0000. busy falls at edge k+2.
- Back-to-back: PULSE=2, GAP=0. Push 0 then 15 on consecutive edges → onehot 0x0001, 0x0001, 0x8000, 0x8000, with no zero cycle between.
- Gap: PULSE=1, GAP=3. Push 3, 4 → 0x0008, then 0,0,0, then 0x0010. strobe_active matches onehot != 0.
- Full: DEPTH=4, PULSE=8. Hold in_valid with indices 1..6 → in_ready drops when fifo_level = 4 while 1 is strobing. All six strobes appear in order 1..6 with none lost or duplicated.
- Flush/reset: assert flush during the second cycle of a PULSE=4 strobe with 2 entries queued → onehot = 0 next edge, fifo_level = 0, no further strobes. Repeat with rst_n low → all outputs at their reset values.
- Round trip: push all 16 indices and feed onehot into the 16→4 priority encoder → encoder output equals each pushed index, and onehot popcount ≤ 1 every cycle.
